cnn_ram_loader: RTL
===================

# cnn_ram_loader

Streaming writer that fills the CNN image and weight RAMs consumed by the data-reuse datapath. After a start pulse it accepts 32-bit words over a valid/ready handshake and packs four words into each 128-bit RAM line. It writes IMG_DEPTH lines to the image RAM, then WGT_DEPTH lines to the weight RAM, and pulses done. It sits between the host/DMA stream and the RAM write ports, which the dataReuse read side later reads.

## Interface
Parameters:
- IMG_DEPTH, 256, number of 128-bit lines written to the image RAM (≥1)
- WGT_DEPTH, 64, number of 128-bit lines written to the weight RAM (≥1)
- ADDR_W, 8, RAM address width; 2^ADDR_W ≥ max(IMG_DEPTH, WGT_DEPTH)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- in_valid  in  1  input word valid
- in_data  in  32  input word
- in_ready  out  1  loader accepts a word; handshake = in_valid & in_ready
- ramImage_we  out  1  image RAM write enable, one-cycle pulse per line
- ramImage_addr  out  ADDR_W  image RAM line address
- ramImage_din  out  128  image RAM write data
- ramWeight_we  out  1  weight RAM write enable
- ramWeight_addr  out  ADDR_W  weight RAM line address
- ramWeight_din  out  128  weight RAM write data
- busy  out  1  high in LOAD_IMG and LOAD_WGT
- done  out  1  one-cycle pulse after the last weight line is written
- checksum  out  32  XOR of all accepted words (see Configuration)

## Operation
- FSM states: IDLE, LOAD_IMG, LOAD_WGT, DONE.
  - IDLE→LOAD_IMG on start.
  - LOAD_IMG→LOAD_WGT on the handshake completing image line IMG_DEPTH-1.
  - LOAD_WGT→DONE on the handshake completing weight line WGT_DEPTH-1.
  - DONE→IDLE unconditionally.
- in_ready = 1 in LOAD_IMG and LOAD_WGT, 0 otherwise. The loader never back-pressures mid-load.
- Packing:
  - 2-bit lane counter starts at 0 on entry to each LOAD state.
  - Accepted word k of a line is stored in bits [32k+31:32k]; the first word goes to [31:0].
  - On the 4th handshake (lane 3), the packed line and current address are registered to the selected RAM's din/addr, and that RAM's we is pulsed.
- Addresses:
  - Line counters start at 0 on start.
  - A counter increments after each write.
  - Image and weight counters are independent.
- start while not in IDLE is ignored.
- in_data without in_valid is ignored. in_valid in IDLE/DONE is not accepted.
- Outputs while a RAM is not being written:
  - we = 0.
  - addr and din hold their last written value.

## Timing
- Reset values: in_ready=0, both we=0, both addr=0, both din=0, busy=0, done=0, checksum=0, state=IDLE, lane=0.
- Reset mid-load returns to IDLE immediately. The partial line is discarded and no write is issued.
- start at edge N: state=LOAD_IMG and in_ready=1 from cycle N+1.
- Write latency: the 4th handshake at edge M drives we=1 during cycle M+1 (registered), for exactly one cycle.
- Image→weight switch:
  - The last image line's we pulse and the first weight-phase in_ready are in the same cycle.
  - No bubble is inserted, and the next accepted word is weight lane 0.
- Last weight handshake at edge M:
  - Cycle M+1: ramWeight_we=1, done=1, busy=0, in_ready=0 (state DONE).
  - Cycle M+2: IDLE.
- busy is a registered decode of state.
- Minimum load duration is 4·(IMG_DEPTH+WGT_DEPTH) accepted cycles plus 2.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A 32-bit register XORs every accepted in_data word.
  - It is cleared to 0 on the start that enters LOAD_IMG.
  - It is held stable from DONE until the next start and is driven on checksum.
- LOADER_CHECKSUM_EN undefined: no register is built and checksum is tied to 32'h0.

## Test plan
Bench uses IMG_DEPTH=4, WGT_DEPTH=2.
- Basic load: start, then stream words 0x00000000…0x00000017 with continuous valid → image lines 0–3 written, line 0 = 0x00000003_00000002_00000001_00000000; weight line 1 = 0x00000017_00000016_00000015_00000014; done pulses once; exactly 6 we pulses total.
- Valid gaps: same data with in_valid toggling every other cycle → identical RAM contents and addresses; each we lasts exactly 1 cycle.
- Phase switch: the cycle with ramImage_we=1 at addr=3 has in_ready=1; word 0x10 lands in weight line 0 bits [31:0] with no idle cycle.
- Reset mid-load: assert rst after 6 words (one line written plus 2 words) → all outputs return to reset values at once; a new start and a full stream rewrite image line 0 from address 0.
- Ignored start: pulse start during LOAD_WGT → no counter reset; the load completes normally with a single done.
- Checksum (LOADER_CHECKSUM_EN defined): stream 0x1 through 0x18 → checksum = 0x00000018 at done; without the macro, checksum stays 0 throughout.

Source files
------------

// File: rtl/cnn_ram_loader.sv
// Packs a 32-bit valid/ready word stream into 128-bit lines for the CNN image RAM, then the weight RAM.
// Write latency 1 cycle after the 4th word of a line; never back-pressures mid-load (in_ready=0 only outside a load).
// Optional feature: LOADER_CHECKSUM_EN builds an XOR checksum of all accepted words.
module cnn_ram_loader #(
    parameter int IMG_DEPTH = 256,
    parameter int WGT_DEPTH = 64,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              ramImage_we,
    output logic [ADDR_W-1:0] ramImage_addr,
    output logic [127:0]      ramImage_din,
    output logic              ramWeight_we,
    output logic [ADDR_W-1:0] ramWeight_addr,
    output logic [127:0]      ramWeight_din,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD_IMG = 2'd1;
    localparam logic [1:0] S_LOAD_WGT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] WGT_LAST = ADDR_W'(WGT_DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] img_cnt;
    logic [ADDR_W-1:0] wgt_cnt;
    logic [31:0]       word0;
    logic [31:0]       word1;
    logic [31:0]       word2;
    logic              hs;
    logic              line_end;
    logic [127:0]      line;

    assign in_ready = (state == S_LOAD_IMG) || (state == S_LOAD_WGT);
    assign hs       = in_valid && in_ready;
    assign line_end = hs && (lane == 2'd3);
    assign line     = {in_data, word2, word1, word0};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_LOAD_IMG;
            S_LOAD_IMG: if (line_end && img_cnt == IMG_LAST) state_nxt = S_LOAD_WGT;
            S_LOAD_WGT: if (line_end && wgt_cnt == WGT_LAST) state_nxt = S_DONE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            lane           <= 2'd0;
            img_cnt        <= '0;
            wgt_cnt        <= '0;
            word0          <= '0;
            word1          <= '0;
            word2          <= '0;
            ramImage_we    <= 1'b0;
            ramImage_addr  <= '0;
            ramImage_din   <= '0;
            ramWeight_we   <= 1'b0;
            ramWeight_addr <= '0;
            ramWeight_din  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt == S_LOAD_IMG) || (state_nxt == S_LOAD_WGT);
            ramImage_we  <= 1'b0;
            ramWeight_we <= 1'b0;
            done         <= 1'b0;

            if (state == S_IDLE && start) begin
                lane    <= 2'd0;
                img_cnt <= '0;
                wgt_cnt <= '0;
            end

            // Lane wraps 3->0 on the line-completing word, so each phase starts at lane 0.
            if (hs) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0: word0 <= in_data;
                    2'd1: word1 <= in_data;
                    2'd2: word2 <= in_data;
                    default: begin
                        if (state == S_LOAD_IMG) begin
                            ramImage_we   <= 1'b1;
                            ramImage_addr <= img_cnt;
                            ramImage_din  <= line;
                            img_cnt       <= img_cnt + 1'b1;
                        end else begin
                            ramWeight_we   <= 1'b1;
                            ramWeight_addr <= wgt_cnt;
                            ramWeight_din  <= line;
                            wgt_cnt        <= wgt_cnt + 1'b1;
                            done           <= (wgt_cnt == WGT_LAST);
                        end
                    end
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == S_IDLE && start) begin
            sum_q <= '0;
        end else if (hs) begin
            sum_q <= sum_q ^ in_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
